axis_sample_packer: RTL and testbench

// - Sits directly downstream of the ADC capture stage. Consumes its 32-bit tagged sample stream, which has no tready.
// - Packs word pairs into 64-bit beats and frames each series with tlast on the end-tagged word.
// - Buffers beats in a FWFT FIFO so the DMA writer can apply back-pressure; overflow is dropped and counted.

---
 rtl/adc_stream_pkg.sv | 35 +++
 rtl/sync_fifo_fwft.sv | 62 ++++++
 rtl/axis_sample_packer.sv | 159 +++++++++++++++
 tb/tb_axis_sample_packer.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_stream_pkg.sv
// Shared definitions for the ADC sample stream.
// Input word layout: [31:30] tag, [29:15] channel A, [14:0] channel B.
// A packed beat is two input words plus a series-end marker.
package adc_stream_pkg;

   localparam logic [1:0] TAG_PAD  = 2'b00;
   localparam logic [1:0] TAG_INV  = 2'b01;
   localparam logic [1:0] TAG_DATA = 2'b10;
   localparam logic [1:0] TAG_END  = 2'b11;

   localparam int unsigned TAG_MSB = 31;
   localparam int unsigned TAG_LSB = 30;
   localparam int unsigned CHA_MSB = 29;
   localparam int unsigned CHB_MSB = 14;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BEAT_W = 64;

   // One FIFO entry: output beat plus its tlast.
   typedef struct packed {
      logic              last;
      logic [BEAT_W-1:0] data;
   } beat_t;

   typedef enum logic {
      HalfEmpty,
      HalfFull
   } pack_state_e;

   // DATA and END carry samples; PAD and the invalid tag do not.
   function automatic logic is_sample_tag(input logic [1:0] tag);
      return tag[1];
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   aclk, aresetn       clock, async active-low reset
//   push, push_data     write request and data (written on the clock edge)
//   push_ok             write accepted this cycle (not full, or full with a pop)
//   pop                 read request; ignored when empty
//   pop_data            head entry, valid whenever empty is low; zero when empty
//   full, empty, level  occupancy status, level in 0..2**AW
module sync_fifo_fwft #(
   parameter int unsigned WIDTH = 65,
   parameter int unsigned AW    = 4
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             push_ok,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr_q, rptr_q;
   logic             pop_ok;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign level   = wptr_q - rptr_q;
   assign pop_ok  = pop & ~empty;
   // A pop at full frees the head slot in the same edge, so the push fits.
   assign push_ok = push & (~full | pop_ok);

   // Gate the head so an empty FIFO presents zero data.
   assign pop_data = empty ? '0 : mem[rptr_q[AW-1:0]];

   always_ff @(posedge aclk) begin
      if (push_ok) begin
         mem[wptr_q[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_ok) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop_ok) begin
            rptr_q <= rptr_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_sample_packer.sv
// Packs pairs of 32-bit tagged ADC words into 64-bit AXI-Stream beats.
// Ports:
//   aclk, aresetn            clock, async active-low reset
//   s_axis_tvalid/tdata      input words, no back-pressure; [31:30] tag
//   flush                    pulse: close the current series, padding a half beat
//   clear_stats              pulse: zero counters and overflow flag
//   m_axis_*                 output beats; tdata[31:0] older word, [63:32] newer word
//   beats_pushed             beats written into the FIFO (saturating)
//   beats_dropped            beats lost to a full FIFO (saturating)
//   bad_words                input words tagged PAD or invalid (saturating)
//   overflow                 sticky, set on any drop
//   fifo_level               current FIFO occupancy
module axis_sample_packer
   import adc_stream_pkg::*;
#(
   parameter int unsigned FIFO_AW = 4,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                s_axis_tvalid,
   input  logic [WORD_W-1:0]   s_axis_tdata,
   input  logic                flush,
   input  logic                clear_stats,
   input  logic                m_axis_tready,
   output logic                m_axis_tvalid,
   output logic [BEAT_W-1:0]   m_axis_tdata,
   output logic                m_axis_tlast,
   output logic [CNT_W-1:0]    beats_pushed,
   output logic [CNT_W-1:0]    beats_dropped,
   output logic [CNT_W-1:0]    bad_words,
   output logic                overflow,
   output logic [FIFO_AW:0]    fifo_level
);

   logic [1:0]  in_tag;
   logic        word_ok;
   logic        word_bad;
   logic        word_end;

   pack_state_e       state_q;
   logic [WORD_W-1:0] low_q;
   logic              push_q;
   beat_t             push_beat_q;

   beat_t fifo_head;
   logic  fifo_full;
   logic  fifo_empty;
   logic  fifo_pop;
   logic  fifo_push_ok;
   logic  push_drop;

   logic [CNT_W-1:0] beats_pushed_q, beats_dropped_q, bad_words_q;
   logic             overflow_q;

   assign in_tag   = s_axis_tdata[TAG_MSB:TAG_LSB];
   assign word_ok  = s_axis_tvalid & is_sample_tag(in_tag);
   assign word_bad = s_axis_tvalid & ~is_sample_tag(in_tag);
   // A flush riding on a sample word turns that word into the series end.
   assign word_end = word_ok & ((in_tag == TAG_END) | flush);

   // Packer FSM; the completed beat is registered and written to the FIFO next cycle.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= HalfEmpty;
         low_q       <= '0;
         push_q      <= 1'b0;
         push_beat_q <= '0;
      end else begin
         push_q <= 1'b0;
         case (state_q)
            HalfEmpty: begin
               if (word_ok) begin
                  if (word_end) begin
                     push_q      <= 1'b1;
                     push_beat_q <= '{last: 1'b1, data: {{WORD_W{1'b0}}, s_axis_tdata}};
                  end else begin
                     low_q   <= s_axis_tdata;
                     state_q <= HalfFull;
                  end
               end
            end
            HalfFull: begin
               if (word_ok) begin
                  push_q      <= 1'b1;
                  push_beat_q <= '{last: word_end, data: {s_axis_tdata, low_q}};
                  state_q     <= HalfEmpty;
               end else if (flush) begin
                  push_q      <= 1'b1;
                  push_beat_q <= '{last: 1'b1, data: {{WORD_W{1'b0}}, low_q}};
                  state_q     <= HalfEmpty;
               end
            end
            default: state_q <= HalfEmpty;
         endcase
      end
   end

   assign fifo_pop  = m_axis_tvalid & m_axis_tready;
   assign push_drop = push_q & ~fifo_push_ok;

   sync_fifo_fwft #(
      .WIDTH ($bits(beat_t)),
      .AW    (FIFO_AW)
   ) u_fifo (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .push      (push_q),
      .push_data (push_beat_q),
      .push_ok   (fifo_push_ok),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign m_axis_tvalid = ~fifo_empty;
   assign m_axis_tdata  = fifo_head.data;
   assign m_axis_tlast  = fifo_head.last;

   // Status counters saturate; clear_stats overrides any coincident update.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         beats_pushed_q  <= '0;
         beats_dropped_q <= '0;
         bad_words_q     <= '0;
         overflow_q      <= 1'b0;
      end else if (clear_stats) begin
         beats_pushed_q  <= '0;
         beats_dropped_q <= '0;
         bad_words_q     <= '0;
         overflow_q      <= 1'b0;
      end else begin
         if (fifo_push_ok && (beats_pushed_q != '1)) begin
            beats_pushed_q <= beats_pushed_q + CNT_W'(1);
         end
         if (push_drop && (beats_dropped_q != '1)) begin
            beats_dropped_q <= beats_dropped_q + CNT_W'(1);
         end
         if (word_bad && (bad_words_q != '1)) begin
            bad_words_q <= bad_words_q + CNT_W'(1);
         end
         if (push_drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // fifo_full is implied by push_drop; kept as a named net for debug visibility.
   logic unused_full;
   assign unused_full = fifo_full;

   assign beats_pushed  = beats_pushed_q;
   assign beats_dropped = beats_dropped_q;
   assign bad_words     = bad_words_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_axis_sample_packer.sv
module tb_axis_sample_packer;

   localparam int unsigned FIFO_AW = 4;
   localparam int unsigned CNT_W   = 32;

   typedef logic [64:0] tb_beat_t;

   logic                aclk = 1'b0;
   logic                aresetn = 1'b0;
   logic                s_axis_tvalid = 1'b0;
   logic [31:0]         s_axis_tdata = '0;
   logic                flush = 1'b0;
   logic                clear_stats = 1'b0;
   logic                m_axis_tready = 1'b0;
   logic                m_axis_tvalid;
   logic [63:0]         m_axis_tdata;
   logic                m_axis_tlast;
   logic [CNT_W-1:0]    beats_pushed;
   logic [CNT_W-1:0]    beats_dropped;
   logic [CNT_W-1:0]    bad_words;
   logic                overflow;
   logic [FIFO_AW:0]    fifo_level;

   int total = 0;
   int bad   = 0;

   // Reference model state: beats the stream should produce, pending half, bad count.
   tb_beat_t    exp_q[$];
   tb_beat_t    got_q[$];
   logic [31:0] pend_q[$];
   int unsigned m_bad = 0;

   axis_sample_packer #(
      .FIFO_AW (FIFO_AW),
      .CNT_W   (CNT_W)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tdata  (s_axis_tdata),
      .flush         (flush),
      .clear_stats   (clear_stats),
      .m_axis_tready (m_axis_tready),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .beats_pushed  (beats_pushed),
      .beats_dropped (beats_dropped),
      .bad_words     (bad_words),
      .overflow      (overflow),
      .fifo_level    (fifo_level)
   );

   always #5 aclk = ~aclk;

   // Inputs change 1ns after posedge, so the negedge view equals the next handshake.
   always @(negedge aclk) begin
      if (aresetn && m_axis_tvalid && m_axis_tready) begin
         got_q.push_back({m_axis_tlast, m_axis_tdata});
      end
   end

   task automatic model_cycle(input bit v, input logic [31:0] d, input bit fl);
      logic [31:0] lo;
      bit          sample;
      bit          is_end;
      sample = v && d[31];
      is_end = (d[31:30] == 2'b11) || fl;
      if (v && !d[31]) m_bad++;
      if (sample) begin
         if (pend_q.size() != 0) begin
            lo = pend_q.pop_front();
            exp_q.push_back({is_end, d, lo});
         end else if (is_end) begin
            exp_q.push_back({1'b1, 32'h0, d});
         end else begin
            pend_q.push_back(d);
         end
      end else if (fl && pend_q.size() != 0) begin
         lo = pend_q.pop_front();
         exp_q.push_back({1'b1, 32'h0, lo});
      end
   endtask

   task automatic step(input bit v, input logic [31:0] d, input bit fl, input bit clr);
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      flush         = fl;
      clear_stats   = clr;
      model_cycle(v, d, fl);
      if (clr) m_bad = 0;
      @(posedge aclk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      flush         = 1'b0;
      clear_stats   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   // Bounded wait for the output to empty; a timeout shows up as a count mismatch.
   task automatic drain();
      for (int i = 0; i < 400; i++) begin
         if (got_q.size() >= exp_q.size() && !m_axis_tvalid) break;
         idle(1);
      end
      idle(2);
   endtask

   function automatic logic [31:0] rand_data();
      return {2'b10, 30'($urandom)};
   endfunction

   task automatic test_reset();
      aresetn = 1'b0;
      #1;
      total++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, overflow} !== '0) begin
         bad++;
         $display("FAIL reset_axis: got v=%0b d=%h l=%0b ovf=%0b want all 0",
                  m_axis_tvalid, m_axis_tdata, m_axis_tlast, overflow);
      end
      total++;
      if ({beats_pushed, beats_dropped, bad_words, fifo_level} !== '0) begin
         bad++;
         $display("FAIL reset_stats: got p=%0d d=%0d b=%0d lvl=%0d want 0",
                  beats_pushed, beats_dropped, bad_words, fifo_level);
      end
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      idle(2);
      total++;
      if (m_axis_tvalid !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle_valid: got %0b want 0", m_axis_tvalid);
      end
   endtask

   task automatic test_basic();
      got_q.delete();
      exp_q.delete();
      m_axis_tready = 1'b1;
      step(1'b1, 32'h8000_0001, 1'b0, 1'b0);
      step(1'b1, 32'h8000_0002, 1'b0, 1'b0);
      total++;
      if (m_axis_tvalid !== 1'b0) begin
         bad++;
         $display("FAIL latency_early: tvalid got %0b want 0 one cycle after word 2",
                  m_axis_tvalid);
      end
      step(1'b1, 32'h8000_0003, 1'b0, 1'b0);
      total++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {2'b10, 64'h80000002_80000001}) begin
         bad++;
         $display("FAIL latency_beat: got v=%0b l=%0b d=%h want v=1 l=0 d=80000002_80000001",
                  m_axis_tvalid, m_axis_tlast, m_axis_tdata);
      end
      step(1'b1, 32'h8000_0004, 1'b0, 1'b0);
      drain();
      total++;
      if (got_q.size() != 2 || exp_q.size() != 2) begin
         bad++;
         $display("FAIL basic_count: got %0d beats want 2", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < 2; i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL basic_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_end_tag();
      got_q.delete();
      exp_q.delete();
      m_axis_tready = 1'b1;
      step(1'b1, 32'h8000_0001, 1'b0, 1'b0);
      step(1'b1, 32'h8000_0002, 1'b0, 1'b0);
      step(1'b1, 32'h8000_0003, 1'b0, 1'b0);
      step(1'b1, 32'hC000_0007, 1'b0, 1'b0);
      step(1'b1, rand_data(), 1'b0, 1'b0);
      step(1'b1, {2'b11, 30'($urandom)}, 1'b0, 1'b0);
      drain();
      total++;
      if (got_q.size() != 3) begin
         bad++;
         $display("FAIL end_count: got %0d beats want 3", got_q.size());
      end
      total++;
      if (got_q.size() > 1 && got_q[1] !== {1'b1, 64'hC0000007_80000003}) begin
         bad++;
         $display("FAIL end_beat: got %h want 1_c0000007_80000003", got_q[1]);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL end_seq%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_flush();
      logic [31:0] w;
      got_q.delete();
      exp_q.delete();
      m_axis_tready = 1'b1;
      step(1'b1, 32'h8000_00AA, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      drain();
      total++;
      if (got_q.size() != 1 || got_q[0] !== {1'b1, 64'h00000000_800000AA}) begin
         bad++;
         $display("FAIL flush_pad: got %0d beats first %h want 1 beat 1_00000000_800000aa",
                  got_q.size(), got_q.size() ? got_q[0] : '0);
      end
      step(1'b0, 32'h0, 1'b1, 1'b0);
      drain();
      total++;
      if (got_q.size() != 1) begin
         bad++;
         $display("FAIL flush_empty_noop: got %0d beats want 1", got_q.size());
      end
      // Flush riding on a word, first with an empty half then with a full one.
      got_q.delete();
      exp_q.delete();
      w = rand_data();
      step(1'b1, w, 1'b1, 1'b0);
      step(1'b1, rand_data(), 1'b0, 1'b0);
      step(1'b1, rand_data(), 1'b1, 1'b0);
      drain();
      total++;
      if (got_q.size() != 2) begin
         bad++;
         $display("FAIL flush_word_count: got %0d beats want 2", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL flush_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_overflow();
      got_q.delete();
      exp_q.delete();
      m_axis_tready = 1'b0;
      step(1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 40; i++) step(1'b1, rand_data(), 1'b0, 1'b0);
      idle(3);
      // Nothing pops, so only the first 16 beats survive.
      exp_q = exp_q[0:15];
      total++;
      if (fifo_level !== 5'd16 || beats_dropped !== 32'd4 || overflow !== 1'b1
          || beats_pushed !== 32'd16) begin
         bad++;
         $display("FAIL overflow_stats: got lvl=%0d drop=%0d ovf=%0b push=%0d want 16 4 1 16",
                  fifo_level, beats_dropped, overflow, beats_pushed);
      end
      m_axis_tready = 1'b1;
      drain();
      total++;
      if (got_q.size() != 16 || m_axis_tvalid !== 1'b0 || fifo_level !== '0) begin
         bad++;
         $display("FAIL overflow_drain: got %0d beats v=%0b lvl=%0d want 16 0 0",
                  got_q.size(), m_axis_tvalid, fifo_level);
      end
      for (int i = 0; i < got_q.size() && i < 16; i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL overflow_order%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_bad_tags();
      got_q.delete();
      exp_q.delete();
      m_axis_tready = 1'b1;
      step(1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b1, rand_data(), 1'b0, 1'b0);
      step(1'b1, 32'h0000_0005, 1'b0, 1'b0);
      step(1'b1, rand_data(), 1'b0, 1'b0);
      step(1'b1, rand_data(), 1'b0, 1'b0);
      step(1'b1, 32'h4000_0005, 1'b0, 1'b0);
      step(1'b1, rand_data(), 1'b0, 1'b0);
      drain();
      total++;
      if (bad_words !== 32'd2 || m_bad != 2) begin
         bad++;
         $display("FAIL bad_words: got %0d want 2", bad_words);
      end
      total++;
      if (got_q.size() != 2) begin
         bad++;
         $display("FAIL bad_tag_count: got %0d beats want 2", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL bad_tag_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
      // Fill the FIFO, then clear in the exact cycle the 17th beat is dropped.
      got_q.delete();
      exp_q.delete();
      m_axis_tready = 1'b0;
      for (int i = 0; i < 32; i++) step(1'b1, rand_data(), 1'b0, 1'b0);
      idle(2);
      step(1'b1, rand_data(), 1'b0, 1'b0);
      step(1'b1, rand_data(), 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      exp_q = exp_q[0:15];
      total++;
      if ({beats_pushed, beats_dropped, bad_words, overflow} !== '0) begin
         bad++;
         $display("FAIL clear_vs_drop: got p=%0d d=%0d b=%0d ovf=%0b want all 0",
                  beats_pushed, beats_dropped, bad_words, overflow);
      end
      total++;
      if (fifo_level !== 5'd16) begin
         bad++;
         $display("FAIL clear_level: got %0d want 16", fifo_level);
      end
      m_axis_tready = 1'b1;
      drain();
      total++;
      if (got_q.size() != 16) begin
         bad++;
         $display("FAIL clear_drain: got %0d beats want 16", got_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w0, w1;
      got_q.delete();
      exp_q.delete();
      m_axis_tready = 1'b0;
      for (int i = 0; i < 11; i++) step(1'b1, rand_data(), 1'b0, 1'b0);
      idle(2);
      total++;
      if (fifo_level !== 5'd5) begin
         bad++;
         $display("FAIL reset_mid_level: got %0d want 5", fifo_level);
      end
      aresetn = 1'b0;
      #1;
      total++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, overflow, beats_pushed, beats_dropped,
           bad_words, fifo_level} !== '0) begin
         bad++;
         $display("FAIL reset_mid_outputs: got v=%0b d=%h lvl=%0d push=%0d want all 0",
                  m_axis_tvalid, m_axis_tdata, fifo_level, beats_pushed);
      end
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      pend_q.delete();
      exp_q.delete();
      got_q.delete();
      m_bad = 0;
      m_axis_tready = 1'b1;
      w0 = rand_data();
      w1 = rand_data();
      step(1'b1, w0, 1'b0, 1'b0);
      step(1'b1, w1, 1'b0, 1'b0);
      drain();
      total++;
      if (got_q.size() != 1 || got_q[0] !== {1'b0, w1, w0}) begin
         bad++;
         $display("FAIL reset_mid_clean: got %0d beats first %h want 1 beat %h",
                  got_q.size(), got_q.size() ? got_q[0] : '0, {1'b0, w1, w0});
      end
   endtask

   task automatic test_random();
      int unsigned r;
      logic [31:0] d;
      got_q.delete();
      exp_q.delete();
      step(1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 300; i++) begin
         m_axis_tready = ($urandom % 8) != 0;
         r = $urandom % 16;
         if (r < 10)      d = {2'b10, 30'($urandom)};
         else if (r < 13) d = {2'b11, 30'($urandom)};
         else if (r < 14) d = {2'b00, 30'($urandom)};
         else if (r < 15) d = {2'b01, 30'($urandom)};
         else             d = {2'b10, 30'($urandom)};
         step(($urandom % 4) != 0, d, ($urandom % 16) == 0, 1'b0);
      end
      m_axis_tready = 1'b1;
      step(1'b0, 32'h0, 1'b1, 1'b0);
      drain();
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL random_count: got %0d beats want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL random_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
      total++;
      if (bad_words !== 32'(m_bad) || beats_dropped !== '0
          || beats_pushed !== 32'(exp_q.size())) begin
         bad++;
         $display("FAIL random_stats: got b=%0d d=%0d p=%0d want b=%0d d=0 p=%0d",
                  bad_words, beats_dropped, beats_pushed, m_bad, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_end_tag();
      test_flush();
      test_overflow();
      test_bad_tags();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
